// File: rtl/inst_sequencer_if.sv
// rtl/inst_sequencer_if.sv - program, control and instruction bus of the instruction sequencer
interface inst_sequencer_if #(
    parameter int OPCODE_BITS = 4,
    parameter int ADDR_BITS   = 8,
    parameter int DEPTH       = 32,
    parameter int CNT_BITS    = 8,
    parameter int STRIDE_BITS = 8,
    parameter int CYC_BITS    = 8
);
    localparam int PC_BITS    = $clog2(DEPTH);
    localparam int ENTRY_BITS = 1 + CYC_BITS + 2 * STRIDE_BITS + CNT_BITS + 2 * ADDR_BITS + OPCODE_BITS;
    localparam int INSTR_BITS = OPCODE_BITS + 2 * ADDR_BITS;

    logic                  prog_we;
    logic [PC_BITS-1:0]    prog_addr;
    logic [ENTRY_BITS-1:0] prog_wdata;
    logic                  start;
    logic                  abort;
    logic                  flag;
    logic [INSTR_BITS-1:0] instruction;
    logic                  busy;
    logic                  done;
    logic                  error;
    logic [PC_BITS-1:0]    pc;

    modport master (
        output prog_we, prog_addr, prog_wdata, start, abort, flag,
        input  instruction, busy, done, error, pc
    );

    modport slave (
        input  prog_we, prog_addr, prog_wdata, start, abort, flag,
        output instruction, busy, done, error, pc
    );
endinterface

// File: rtl/inst_sequencer.sv
// rtl/inst_sequencer.sv - expands a loaded program of loop descriptors into strided systolic-array instructions
module inst_sequencer #(
    parameter int OPCODE_BITS = 4,
    parameter int ADDR_BITS   = 8,
    parameter int DEPTH       = 32,
    parameter int CNT_BITS    = 8,
    parameter int STRIDE_BITS = 8,
    parameter int CYC_BITS    = 8,
    parameter int TIMEOUT     = 4096,
    parameter int IDLE_OPCODE = 0
) (
    input  logic               clk,
    input  logic               reset,
    inst_sequencer_if.slave    bus
);
    localparam int PC_BITS    = $clog2(DEPTH);
    localparam int OFF_A      = OPCODE_BITS;
    localparam int OFF_B      = OFF_A + ADDR_BITS;
    localparam int OFF_CNT    = OFF_B + ADDR_BITS;
    localparam int OFF_SA     = OFF_CNT + CNT_BITS;
    localparam int OFF_SB     = OFF_SA + STRIDE_BITS;
    localparam int OFF_CYC    = OFF_SB + STRIDE_BITS;
    localparam int OFF_MODE   = OFF_CYC + CYC_BITS;
    localparam int ENTRY_BITS = OFF_MODE + 1;
    localparam int INSTR_BITS = OPCODE_BITS + 2 * ADDR_BITS;
    localparam int TMR_BITS   = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_HOLD_C, S_WAIT_LO, S_WAIT_HI, S_DONE, S_ERR
    } state_t;

    state_t                         r_state;
    logic [ENTRY_BITS-1:0]          r_ram [DEPTH];
    logic [ENTRY_BITS-1:0]          r_rdata;
    logic [OPCODE_BITS-1:0]         r_opcode;
    logic [ADDR_BITS-1:0]           r_addra;
    logic [ADDR_BITS-1:0]           r_addrb;
    logic [CNT_BITS-1:0]            r_rep;
    logic signed [STRIDE_BITS-1:0]  r_stride_a;
    logic signed [STRIDE_BITS-1:0]  r_stride_b;
    logic [CYC_BITS-1:0]            r_cycles;
    logic [CYC_BITS-1:0]            r_hold;
    logic                           r_mode;
    logic [TMR_BITS-1:0]            r_timer;
    logic [INSTR_BITS-1:0]          r_instr;
    logic                           r_busy;
    logic                           r_done;
    logic                           r_error;
    logic [PC_BITS-1:0]             r_pc;

    logic [OPCODE_BITS-1:0]         w_opcode;
    logic [ADDR_BITS-1:0]           w_addra;
    logic [ADDR_BITS-1:0]           w_addrb;
    logic [CNT_BITS-1:0]            w_count;
    logic [STRIDE_BITS-1:0]         w_stride_a;
    logic [STRIDE_BITS-1:0]         w_stride_b;
    logic [CYC_BITS-1:0]            w_cycles;
    logic                           w_mode;
    logic [CYC_BITS-1:0]            w_hold_init;
    logic [CYC_BITS-1:0]            w_hold_rel;
    logic [ADDR_BITS-1:0]           w_next_a;
    logic [ADDR_BITS-1:0]           w_next_b;
    logic [INSTR_BITS-1:0]          w_idle;
    logic                           w_end;

    assign w_opcode    = r_rdata[OFF_A-1:0];
    assign w_addra     = r_rdata[OFF_B-1:OFF_A];
    assign w_addrb     = r_rdata[OFF_CNT-1:OFF_B];
    assign w_count     = r_rdata[OFF_SA-1:OFF_CNT];
    assign w_stride_a  = r_rdata[OFF_SB-1:OFF_SA];
    assign w_stride_b  = r_rdata[OFF_CYC-1:OFF_SB];
    assign w_cycles    = r_rdata[OFF_MODE-1:OFF_CYC];
    assign w_mode      = r_rdata[OFF_MODE];

    // a hold count of zero behaves as one cycle
    assign w_hold_init = (w_cycles == '0) ? '0 : w_cycles - CYC_BITS'(1);
    assign w_hold_rel  = (r_cycles == '0) ? '0 : r_cycles - CYC_BITS'(1);
    assign w_next_a    = r_addra + ADDR_BITS'(r_stride_a);
    assign w_next_b    = r_addrb + ADDR_BITS'(r_stride_b);
    assign w_idle      = {OPCODE_BITS'(IDLE_OPCODE), {(2 * ADDR_BITS){1'b0}}};
    assign w_end       = ((r_state == S_HOLD_C) && (r_hold == '0)) ||
                         ((r_state == S_WAIT_HI) && bus.flag);

    // program RAM: writes only land while idle, read is registered every cycle
    always_ff @(posedge clk) begin
        if (bus.prog_we && (r_state == S_IDLE)) begin
            r_ram[bus.prog_addr] <= bus.prog_wdata;
        end
        r_rdata <= r_ram[r_pc];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_opcode   <= '0;
            r_addra    <= '0;
            r_addrb    <= '0;
            r_rep      <= '0;
            r_stride_a <= '0;
            r_stride_b <= '0;
            r_cycles   <= '0;
            r_hold     <= '0;
            r_mode     <= 1'b0;
            r_timer    <= '0;
            r_instr    <= w_idle;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_pc       <= '0;
        end else begin
            r_done <= 1'b0;
            if (bus.abort && (r_state != S_IDLE)) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_instr <= w_idle;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.start) begin
                            r_state <= S_FETCH;
                            r_pc    <= '0;
                            r_busy  <= 1'b1;
                            r_error <= 1'b0;
                        end
                    end
                    S_FETCH: r_state <= S_LOAD;
                    S_LOAD: begin
                        if (w_count == '0) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_opcode   <= w_opcode;
                            r_addra    <= w_addra;
                            r_addrb    <= w_addrb;
                            r_rep      <= w_count;
                            r_stride_a <= w_stride_a;
                            r_stride_b <= w_stride_b;
                            r_cycles   <= w_cycles;
                            r_mode     <= w_mode;
                            r_hold     <= w_hold_init;
                            r_timer    <= '0;
                            r_instr    <= {w_opcode, w_addra, w_addrb};
                            r_state    <= w_mode ? S_WAIT_LO : S_HOLD_C;
                        end
                    end
                    S_HOLD_C, S_WAIT_LO, S_WAIT_HI: begin
                        if (w_end) begin
                            if (r_rep > CNT_BITS'(1)) begin
                                r_rep   <= r_rep - CNT_BITS'(1);
                                r_addra <= w_next_a;
                                r_addrb <= w_next_b;
                                r_instr <= {r_opcode, w_next_a, w_next_b};
                                r_hold  <= w_hold_rel;
                                r_timer <= '0;
                                r_state <= r_mode ? S_WAIT_LO : S_HOLD_C;
                            end else begin
                                r_instr <= w_idle;
                                if (r_pc == PC_BITS'(DEPTH - 1)) begin
                                    r_state <= S_DONE;
                                    r_busy  <= 1'b0;
                                    r_done  <= 1'b1;
                                end else begin
                                    r_pc    <= r_pc + PC_BITS'(1);
                                    r_state <= S_FETCH;
                                end
                            end
                        end else if (r_state == S_HOLD_C) begin
                            r_hold <= r_hold - CYC_BITS'(1);
                        end else if (r_timer == TMR_BITS'(TIMEOUT - 1)) begin
                            r_state <= S_ERR;
                            r_error <= 1'b1;
                            r_busy  <= 1'b0;
                            r_instr <= w_idle;
                        end else begin
                            r_timer <= r_timer + TMR_BITS'(1);
                            if ((r_state == S_WAIT_LO) && !bus.flag) begin
                                r_state <= S_WAIT_HI;
                            end
                        end
                    end
                    S_DONE:  r_state <= S_IDLE;
                    S_ERR:   r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.instruction = r_instr;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.error       = r_error;
    assign bus.pc          = r_pc;
endmodule
